// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed FIR filter.
// Rounding/saturation is enabled at build time with FIR_ROUND_SAT_EN.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  localparam int RW = 64;

  function automatic int acc_width(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + $clog2(taps);
  endfunction

  // Operates on a sign-extended RW-bit value; caller keeps low out_w bits.
  function automatic logic signed [RW-1:0] round_sat(
    input logic signed [RW-1:0] acc,
    input int shift,
    input int out_w
  );
    logic signed [RW-1:0] one;
    logic signed [RW-1:0] v;
    logic signed [RW-1:0] hi;
    logic signed [RW-1:0] lo;
    one = 1;
    v = acc;
    if (shift > 0) v = v + (one <<< (shift - 1));
    v = v >>> shift;
    hi = (one <<< (out_w - 1)) - one;
    lo = -(one <<< (out_w - 1));
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_out_stage.sv
// Combinational accumulator-to-sample shaping (shift, optional round/saturate).
// FIR_ROUND_SAT_EN selects round+saturate; otherwise truncate and wrap.
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int ACC_W = 34,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] data_o
);

  logic signed [RW-1:0] wide;
  logic signed [RW-1:0] res;
  logic unused_hi;

  assign wide = {{(RW-ACC_W){acc_i[ACC_W-1]}}, acc_i};

`ifdef FIR_ROUND_SAT_EN
  assign res = round_sat(wide, SHIFT, OUT_W);
`else
  assign res = wide >>> SHIFT;
`endif

  assign data_o = res[OUT_W-1:0];
  assign unused_hi = ^res[RW-1:OUT_W];

endmodule

// File: rtl/fir_filter_tdm.sv
// Multi-channel FIR sharing one multiplier across taps, with run-time coefficients.
// Output shaping depends on FIR_ROUND_SAT_EN (see fir_out_stage).
module fir_filter_tdm
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int TAPS        = 8,
  parameter int CHANNELS    = 2,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT       = 15,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TW = $clog2(TAPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CW-1:0]                 in_ch,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  input  logic                          coef_we,
  input  logic [TW-1:0]                 coef_addr,
  input  logic signed [COEFF_WIDTH-1:0] coef_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CW-1:0]                 out_ch,
  output logic signed [OUT_WIDTH-1:0]   out_data
);

  localparam int ACC_W = acc_width(DATA_WIDTH, COEFF_WIDTH, TAPS);
  localparam int PW    = DATA_WIDTH + COEFF_WIDTH;

  state_t state_q, state_d;
  logic signed [DATA_WIDTH-1:0]  x_q [CHANNELS][TAPS];
  logic signed [COEFF_WIDTH-1:0] h_q [TAPS];
  logic signed [ACC_W-1:0]       acc_q, acc_d, acc_nx;
  logic [TW-1:0]                 k_q, k_d;
  logic [CW-1:0]                 ch_q, ch_d, out_ch_q;
  logic signed [OUT_WIDTH-1:0]   out_data_q, shaped;
  logic signed [PW-1:0]          prod;
  logic                          accept, ch_ok, start, last;

  assign accept = (state_q == IDLE) && in_valid;
  assign ch_ok  = int'(in_ch) < CHANNELS;
  assign start  = accept && ch_ok;
  assign last   = k_q == TW'(TAPS - 1);
  assign prod   = x_q[ch_q][k_q] * h_q[k_q];
  assign acc_nx = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};

  // Fed with the final sum so the output register loads on the MAC->OUT edge.
  fir_out_stage #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_WIDTH),
    .SHIFT(SHIFT)
  ) u_out (
    .acc_i (acc_nx),
    .data_o(shaped)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    ch_d    = ch_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          acc_d   = '0;
          k_d     = '0;
          ch_d    = in_ch;
        end
      end
      MAC: begin
        acc_d = acc_nx;
        k_d   = k_q + 1'b1;
        if (last) state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      k_q        <= '0;
      ch_q       <= '0;
      out_ch_q   <= '0;
      out_data_q <= '0;
      for (int t = 0; t < TAPS; t++) begin
        h_q[t] <= '0;
        for (int c = 0; c < CHANNELS; c++) x_q[c][t] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      ch_q    <= ch_d;
      if ((state_q == IDLE) && coef_we) h_q[coef_addr] <= coef_data;
      if (start) begin
        for (int t = TAPS - 1; t > 0; t--) x_q[in_ch][t] <= x_q[in_ch][t-1];
        x_q[in_ch][0] <= in_data;
      end
      if ((state_q == MAC) && last) begin
        out_data_q <= shaped;
        out_ch_q   <= ch_q;
      end
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == OUT;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Directed bench for fir_filter_tdm: 8-bit data/coeffs, 4 taps, 2 channels, 16-bit out.
// Saturation expectations follow FIR_ROUND_SAT_EN.
module tb_fir_filter_tdm;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_ch;
  logic signed [7:0] in_data;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_ch;
  logic signed [15:0] out_data;

  int total = 0;
  int bad = 0;
  int lat;

  always #5 clk = ~clk;

  fir_filter_tdm #(
    .DATA_WIDTH (8),
    .COEFF_WIDTH(8),
    .TAPS       (4),
    .CHANNELS   (2),
    .OUT_WIDTH  (16),
    .SHIFT      (0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .in_data  (in_data),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_data (out_data)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wcoef(input int a, input int v);
    coef_we = 1'b1;
    coef_addr = 2'(a);
    coef_data = 8'(v);
    cyc();
    coef_we = 1'b0;
  endtask

  // Leaves the bench in the first OUT cycle; lat counts from the accept cycle.
  task automatic send(input int ch, input int d, input bit midwe);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      cyc();
      n++;
    end
    in_valid = 1'b1;
    in_ch = 1'(ch);
    in_data = 8'(d);
    cyc();
    in_valid = 1'b0;
    if (midwe) begin
      coef_we = 1'b1;
      coef_addr = 2'd0;
      coef_data = 8'sd100;
    end
    lat = 1;
    while (!out_valid && lat < 40) begin
      cyc();
      coef_we = 1'b0;
      lat++;
    end
    coef_we = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int ch, input int d,
                            input int y, input bit midwe);
    send(ch, d, midwe);
    chk({tag, ".lat"}, lat, 5);
    chk({tag, ".ch"}, out_ch, ch);
    chk({tag, ".data"}, out_data, y);
    cyc();
    chk({tag, ".drop"}, out_valid, 0);
  endtask

  initial begin
    int imp[5];
    int hr[5];
    int c1[5];
    int sat4;
    imp = '{1, 0, 0, 0, 0};
    hr  = '{3, 5, 5, 3, 0};
    c1  = '{30, 80, 130, 160, 160};
`ifdef FIR_ROUND_SAT_EN
    sat4 = 32767;
`else
    sat4 = -1020;
`endif
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_ch = 1'b0;
    in_data = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_ch", out_ch, 0);
    chk("rst.out_data", out_data, 0);

    wcoef(0, 3); wcoef(1, 5); wcoef(2, 5); wcoef(3, 3);
    for (int i = 0; i < 5; i++)
      expect_out($sformatf("imp%0d", i), 0, imp[i], hr[i], 1'b0);

    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("iso0_%0d", i), 0, imp[i], hr[i], 1'b0);
      expect_out($sformatf("iso1_%0d", i), 1, 10, c1[i], 1'b0);
    end
    expect_out("iso1_4", 1, 10, c1[4], 1'b0);

    out_ready = 1'b0;
    send(0, 2, 1'b0);
    chk("bp.lat", lat, 5);
    chk("bp.data0", out_data, 6);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("bp.valid%0d", i), out_valid, 1);
      chk($sformatf("bp.data%0d", i), out_data, 6);
      chk($sformatf("bp.ch%0d", i), out_ch, 0);
      chk($sformatf("bp.ready%0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp.release_valid", out_valid, 0);
    chk("bp.release_ready", in_ready, 1);

    expect_out("cwmid", 0, 1, 13, 1'b1);
    expect_out("cwafter", 0, 1, 18, 1'b0);

    wcoef(0, 127); wcoef(1, 127); wcoef(2, 127); wcoef(3, 127);
    expect_out("sat0", 1, 127, 19939, 1'b0);
    send(1, 127, 1'b0);
    cyc();
    send(1, 127, 1'b0);
    cyc();
    expect_out("sat3", 1, 127, sat4, 1'b0);

    send(0, 5, 1'b0);
    cyc();
    in_valid = 1'b1;
    in_ch = 1'b0;
    in_data = 8'sd5;
    cyc();
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rstmac.out_valid", out_valid, 0);
    chk("rstmac.in_ready", in_ready, 1);
    chk("rstmac.out_data", out_data, 0);
    for (int i = 0; i < 6; i++) cyc();
    chk("rstmac.idle_valid", out_valid, 0);

    wcoef(0, 3); wcoef(1, 5); wcoef(2, 5); wcoef(3, 3);
    for (int i = 0; i < 4; i++)
      expect_out($sformatf("post%0d", i), 0, imp[i], hr[i], 1'b0);
    expect_out("post_ch1", 1, 1, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
